// File: rtl/taxi_axi_regfile_pkg.sv
// ============================================================================
// Package : taxi_axi_regfile_pkg
// Shared FSM state types and AXI burst/response encodings for the register file.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package taxi_axi_regfile_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

`default_nettype wire

// File: rtl/taxi_axi_regfile_if.sv
// ============================================================================
// Interface : taxi_axi_if
// AXI4 channel bundle with split write/read modports for master and slave.
// Rev       : 1.0
// ============================================================================
`default_nettype none

interface taxi_axi_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int STRB_W = DATA_W / 8,
  parameter int ID_W   = 8
) ();

  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;

  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport wr_slv (
    input  awid, awaddr, awlen, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready
  );

  modport rd_slv (
    input  arid, araddr, arlen, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );

  modport wr_mst (
    output awid, awaddr, awlen, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready
  );

  modport rd_mst (
    output arid, araddr, arlen, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );

endinterface

`default_nettype wire

// File: rtl/taxi_axi_regfile_addr_gen.sv
// ============================================================================
// Module : taxi_axi_regfile_addr_gen
// Next word index for a burst plus out-of-range flag (TAXI_AXI_REGFILE_ERR_EN).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module taxi_axi_regfile_addr_gen
  import taxi_axi_regfile_pkg::*;
#(
  parameter int IDX_W = 32,
  parameter int DEPTH = 256
) (
  input  logic [IDX_W-1:0] cur_idx,
  input  logic [1:0]       burst,
  output logic [IDX_W-1:0] next_idx,
  output logic             out_of_range
);

  always_comb begin
    // WRAP bursts deliberately advance like INCR
    next_idx = (burst == BURST_FIXED) ? cur_idx : cur_idx + IDX_W'(1);
`ifdef TAXI_AXI_REGFILE_ERR_EN
    out_of_range = ({1'b0, cur_idx} >= (IDX_W+1)'(DEPTH));
`else
    out_of_range = 1'b0;
`endif
  end

endmodule

`default_nettype wire

// File: rtl/taxi_axi_regfile.sv
// ============================================================================
// Module : taxi_axi_regfile
// AXI4 burst slave over a flip-flop word array; SLVERR on TAXI_AXI_REGFILE_ERR_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module taxi_axi_regfile
  import taxi_axi_regfile_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic       clk,
  input  logic       rst,
  taxi_axi_if.wr_slv s_axi_wr,
  taxi_axi_if.rd_slv s_axi_rd
);

  localparam int DATA_W   = s_axi_wr.DATA_W;
  localparam int ADDR_W   = s_axi_wr.ADDR_W;
  localparam int STRB_W   = s_axi_wr.STRB_W;
  localparam int ID_W     = s_axi_wr.ID_W;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  // Keeps both ready outputs low until the first edge after reset release
  logic run;

  wr_state_t         wr_state, wr_state_next;
  logic [ID_W-1:0]   wr_id;
  logic [ADDR_W-1:0] wr_idx, wr_idx_next;
  logic [7:0]        wr_len, wr_cnt;
  logic [1:0]        wr_burst;
  logic              wr_err, wr_oor;
  logic              aw_hs, w_hs;

  rd_state_t         rd_state, rd_state_next;
  logic [ID_W-1:0]   rd_id;
  logic [ADDR_W-1:0] rd_idx, rd_idx_next, rd_cur;
  logic [7:0]        rd_len, rd_cnt;
  logic [1:0]        rd_burst, rd_cur_burst, rd_resp;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last, rd_oor;
  logic              ar_hs, r_hs;

  taxi_axi_regfile_addr_gen #(.IDX_W(ADDR_W), .DEPTH(DEPTH)) u_wr_gen (
    .cur_idx     (wr_idx),
    .burst       (wr_burst),
    .next_idx    (wr_idx_next),
    .out_of_range(wr_oor)
  );

  taxi_axi_regfile_addr_gen #(.IDX_W(ADDR_W), .DEPTH(DEPTH)) u_rd_gen (
    .cur_idx     (rd_cur),
    .burst       (rd_cur_burst),
    .next_idx    (rd_idx_next),
    .out_of_range(rd_oor)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run      <= 1'b0;
      wr_state <= W_IDLE;
      rd_state <= R_IDLE;
    end else begin
      run      <= 1'b1;
      wr_state <= wr_state_next;
      rd_state <= rd_state_next;
    end
  end

  always_comb begin
    wr_state_next    = wr_state;
    aw_hs            = 1'b0;
    w_hs             = 1'b0;
    s_axi_wr.awready = 1'b0;
    s_axi_wr.wready  = 1'b0;
    s_axi_wr.bvalid  = 1'b0;
    s_axi_wr.bid     = wr_id;
    s_axi_wr.bresp   = (wr_state == W_RESP && wr_err) ? RESP_SLVERR : RESP_OKAY;
    case (wr_state)
      W_IDLE: begin
        s_axi_wr.awready = run;
        if (run && s_axi_wr.awvalid) begin
          aw_hs         = 1'b1;
          wr_state_next = W_DATA;
        end
      end
      W_DATA: begin
        s_axi_wr.wready = 1'b1;
        if (s_axi_wr.wvalid) begin
          w_hs = 1'b1;
          if (s_axi_wr.wlast || wr_cnt == wr_len) wr_state_next = W_RESP;
        end
      end
      W_RESP: begin
        s_axi_wr.bvalid = 1'b1;
        if (s_axi_wr.bready) wr_state_next = W_IDLE;
      end
      default: wr_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_id    <= '0;
      wr_idx   <= '0;
      wr_len   <= '0;
      wr_cnt   <= '0;
      wr_burst <= '0;
      wr_err   <= 1'b0;
    end else begin
      if (aw_hs) begin
        wr_id    <= s_axi_wr.awid;
        wr_idx   <= s_axi_wr.awaddr >> ADDR_LSB;
        wr_len   <= s_axi_wr.awlen;
        wr_burst <= s_axi_wr.awburst;
        wr_cnt   <= '0;
        wr_err   <= 1'b0;
      end
      if (w_hs) begin
        wr_idx <= wr_idx_next;
        wr_cnt <= wr_cnt + 8'd1;
        if (wr_oor) wr_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && !wr_oor) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_wr.wstrb[b]) mem[wr_idx[IDX_W-1:0]][b*8 +: 8] <= s_axi_wr.wdata[b*8 +: 8];
      end
    end
  end

  always_comb begin
    rd_state_next    = rd_state;
    ar_hs            = 1'b0;
    r_hs             = 1'b0;
    s_axi_rd.arready = 1'b0;
    s_axi_rd.rvalid  = 1'b0;
    // In idle the generator looks at the incoming AR so the first word is ready next cycle
    rd_cur           = (rd_state == R_IDLE) ? (s_axi_rd.araddr >> ADDR_LSB) : rd_idx;
    rd_cur_burst     = (rd_state == R_IDLE) ? s_axi_rd.arburst : rd_burst;
    case (rd_state)
      R_IDLE: begin
        s_axi_rd.arready = run;
        if (run && s_axi_rd.arvalid) begin
          ar_hs         = 1'b1;
          rd_state_next = R_DATA;
        end
      end
      R_DATA: begin
        s_axi_rd.rvalid = 1'b1;
        if (s_axi_rd.rready) begin
          r_hs = 1'b1;
          if (rd_last) rd_state_next = R_IDLE;
        end
      end
      default: rd_state_next = R_IDLE;
    endcase
  end

  assign s_axi_rd.rid   = rd_id;
  assign s_axi_rd.rdata = rd_data;
  assign s_axi_rd.rresp = rd_resp;
  assign s_axi_rd.rlast = rd_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_id    <= '0;
      rd_idx   <= '0;
      rd_len   <= '0;
      rd_cnt   <= '0;
      rd_burst <= '0;
      rd_data  <= '0;
      rd_resp  <= RESP_OKAY;
      rd_last  <= 1'b0;
    end else if (ar_hs) begin
      rd_id    <= s_axi_rd.arid;
      rd_len   <= s_axi_rd.arlen;
      rd_burst <= s_axi_rd.arburst;
      rd_cnt   <= '0;
      rd_last  <= (s_axi_rd.arlen == 8'd0);
      rd_idx   <= rd_idx_next;
      rd_data  <= rd_oor ? '0 : mem[rd_cur[IDX_W-1:0]];
      rd_resp  <= rd_oor ? RESP_SLVERR : RESP_OKAY;
    end else if (r_hs) begin
      if (rd_last) begin
        rd_last <= 1'b0;
      end else begin
        rd_cnt  <= rd_cnt + 8'd1;
        rd_last <= (rd_cnt + 8'd1 == rd_len);
        rd_idx  <= rd_idx_next;
        rd_data <= rd_oor ? '0 : mem[rd_cur[IDX_W-1:0]];
        rd_resp <= rd_oor ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/taxi_axi_regfile.md
# taxi_axi_regfile

AXI4 slave register file responding to full AXI4 read and write bursts with a flip-flop storage array. It is the responder end of the AXI master port driven by the XFCP AXI bridge, closing the XFCP-to-AXI path in simulation and in small on-chip control-register maps. Independent read and write state machines allow concurrent bursts. Responses carry OKAY, or SLVERR for out-of-range accesses when error checking is compiled in.

## Interface
- DEPTH, 256: storage words of DATA_W bits; power of two, minimum 2
- Data, address, strobe and ID widths are taken from the bound taxi_axi_if instance: DATA_W, ADDR_W, STRB_W = DATA_W/8, ID_W
- clk  input  1  clock; all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- s_axi_wr  taxi_axi_if.wr_slv  —  AW/W/B channels
- s_axi_rd  taxi_axi_if.rd_slv  —  AR/R channels

## Operation
- Word index = addr >> log2(STRB_W). Low address bits are ignored; unaligned starts are treated as aligned.
- Burst types:
  - INCR: index +1 per beat.
  - FIXED: index held for all beats.
  - WRAP: treated as INCR.
- Write FSM:
  - W_IDLE: awready=1. On AW handshake, latch awid, index, awlen and awburst → W_DATA.
  - W_DATA: wready=1. Each W handshake writes the bytes whose wstrb bit is set. On the beat with wlast=1, or on beat awlen+1, → W_RESP.
  - W_RESP: bvalid=1, bid=latched ID. On bready → W_IDLE.
- Read FSM:
  - R_IDLE: arready=1. On AR handshake, latch ID, index, len and burst. Register the first word → R_DATA.
  - R_DATA: rvalid=1. On each R handshake, load the next word into rdata in the same cycle. rlast=1 on beat arlen. The handshake on the last beat → R_IDLE.
- rid always equals the latched arid.
- Simultaneous read and write to the same word in the same cycle: read returns the old contents.
- Beats past awlen with wlast=0 are not accepted. Early wlast ends the burst; no further W beats are taken for it.

## Timing
- AW handshake at cycle N → wready=1 from N+1.
- Final W handshake at M → bvalid=1 at M+1.
- AR handshake at N → first rvalid at N+1. Further beats go back-to-back while rready=1, giving 1 beat/cycle.
- Minimum write turnaround is AW, W, then B on successive cycles. The next AW is accepted the cycle after the B handshake.
- Reset values: awready=0, wready=0, bvalid=0, arready=0, rvalid=0, rlast=0, bresp=rresp=0, bid=rid=0, rdata=0. The ready outputs rise on the first cycle after rst deasserts.
- Reset mid-burst: both FSMs return to idle immediately and the burst is abandoned. Storage contents are not reset.

## Configuration
- TAXI_AXI_REGFILE_ERR_EN
  - Defined: the out-of-range check uses the full, unmasked index (addr >> log2(STRB_W), no wrap). Any beat whose full index is ≥ DEPTH gets SLVERR (2'b10); writes are dropped and reads return 0. bresp is SLVERR if any beat of the burst erred. rresp is reported per beat.
  - Undefined: the index is taken modulo DEPTH; all responses are OKAY.

## Structure
- Package taxi_axi_regfile_pkg:
  - write state enum: W_IDLE, W_DATA, W_RESP
  - read state enum: R_IDLE, R_DATA
  - burst constants: BURST_FIXED=2'b00, BURST_INCR=2'b01, BURST_WRAP=2'b10
  - response constants: RESP_OKAY=2'b00, RESP_SLVERR=2'b10
- Sub-module taxi_axi_regfile_addr_gen: combinational next-index computation from current index and burst type, plus range flag. Instantiated once per FSM.

## Test plan
- Single write of 0xDEADBEEF to addr 0x10 with wstrb=4'hF, then single read at 0x10 → bresp OKAY; rdata=0xDEADBEEF, rlast=1, rresp OKAY.
- Partial strobe: write 0x11223344 to 0x20, then write 0xAABBCCDD to 0x20 with wstrb=4'b0101; read 0x20 → 0x11BB33DD.
- INCR write of 8 beats (awlen=7) at 0x0 with data 0..7, then INCR read of 8 beats with rready held high → eight consecutive cycles of rvalid, data 0..7, rlast only on beat 8. FIXED 4-beat write of 1..4 at 0x40 → read 0x40 gives 4.
- Concurrent traffic: 16-beat write to 0x100 overlapping a 16-beat read of 0x0 → both complete; read data matches prior contents; IDs 3 (write) and 5 (read) echoed.
- Backpressure: bready low for 5 cycles → bvalid held, awready=0 throughout. Random rready toggling → rdata stable while rvalid=1 and rready=0.
- Range and reset, with ERR_EN:
  - Read at index DEPTH → rresp SLVERR, rdata 0.
  - Without ERR_EN, the same read returns the word at index 0.
  - rst asserted mid read burst → rvalid=0 immediately, next AR accepted normally.
